// File: rtl/sr_pkg.sv
// Shared types and constants for the set/reset command front end.
package sr_pkg;

    typedef enum logic {SR_IDLE, SR_LOCK} sr_state_e;

    localparam logic PRIO_S = 1'b0;
    localparam logic PRIO_R = 1'b1;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request/command bundle between the raw request source and the flop driver.
interface sr_cmd_if;

    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_in, clr_in,
        input  s, r, busy, conflict
    );

    modport slave (
        input  set_in, clr_in,
        output s, r, busy, conflict
    );

endinterface

// File: rtl/sr_debounce.sv
// Run-length debouncer: the output follows the input once it has differed
// for DB_CYCLES consecutive samples; rise flags a debounced rising edge.
module sr_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          db_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dout  <= 1'b0;
            db_p1 <= 1'b0;
        end else begin
            db_p1 <= dout;
            if (din == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                dout <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // db_p1 lags dout by one edge, so rise is high for exactly one cycle
    assign rise = dout & ~db_p1;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear command generator: one-cycle s/r pulses, never both,
// separated by a lockout window; collisions resolved by PRIO_RESET.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int LOCKOUT    = 2,
    parameter bit PRIO_RESET = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    sr_cmd_if.slave  bus
);

    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT - 1);

    sr_state_e     state;
    logic [LW-1:0] lock_cnt;
    logic          pend_s, pend_r;
    logic          s_q, r_q, busy_q, conflict_q;

    logic db_s, db_r;
    logic rise_s, rise_r;
    logic ev_s, ev_r;
    logic cand_s, cand_r;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.set_in),
        .dout (db_s),
        .rise (rise_s)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.clr_in),
        .dout (db_r),
        .rise (rise_r)
    );

    assign ev_s   = rise_s & db_s;
    assign ev_r   = rise_r & db_r;
    assign cand_s = pend_s | ev_s;
    assign cand_r = pend_r | ev_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SR_IDLE;
            lock_cnt   <= '0;
            pend_s     <= 1'b0;
            pend_r     <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            case (state)
                SR_IDLE: begin
                    if (cand_s | cand_r) begin
                        if (cand_s & cand_r) begin
                            // Loser of a collision is dropped, not deferred
                            conflict_q <= 1'b1;
                            if (PRIO_RESET == PRIO_R) r_q <= 1'b1;
                            else                      s_q <= 1'b1;
                        end else begin
                            s_q <= cand_s;
                            r_q <= cand_r;
                        end
                        pend_s   <= 1'b0;
                        pend_r   <= 1'b0;
                        lock_cnt <= LOCK_LOAD;
                        busy_q   <= 1'b1;
                        state    <= SR_LOCK;
                    end
                end
                SR_LOCK: begin
                    pend_s <= pend_s | ev_s;
                    pend_r <= pend_r | ev_r;
                    if (lock_cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= SR_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= SR_IDLE;
                end
            endcase
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Randomised and directed bench for sr_cmd_gen against a schedule-based model.
module tb_sr_cmd_gen;

    localparam int DB  = 4;
    localparam int LO  = 2;
    localparam bit PRI = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_cmd_if bus ();

    sr_cmd_gen #(
        .DB_CYCLES  (DB),
        .LOCKOUT    (LO),
        .PRIO_RESET (PRI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    endtask

    // Model: debounced level per side, run length of disagreeing samples,
    // time of the last issued pulse and pending flags.
    int m_db[2], m_dbprev[2], m_run[2];
    bit m_pend[2];
    int m_edge = 0;
    int m_last = -1000;
    bit exp_s, exp_r, exp_busy, exp_conf;

    task automatic model_step(input bit rs, input bit raw_s, input bit raw_r);
        bit raw[2];
        bit ev[2];
        bit cand[2];
        raw[0] = raw_s;
        raw[1] = raw_r;
        m_edge++;
        exp_s = 0; exp_r = 0; exp_conf = 0; exp_busy = 0;
        if (rs) begin
            for (int k = 0; k < 2; k++) begin
                m_db[k] = 0; m_dbprev[k] = 0; m_run[k] = 0; m_pend[k] = 0;
            end
            m_last = -1000;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            ev[k] = (m_db[k] == 1) && (m_dbprev[k] == 0);
            m_dbprev[k] = m_db[k];
            if (int'(raw[k]) != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] >= DB) begin
                    m_db[k] = raw[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        if (m_edge - m_last >= LO + 1) begin
            for (int k = 0; k < 2; k++) cand[k] = m_pend[k] | ev[k];
            if (cand[0] || cand[1]) begin
                if (cand[0] && cand[1]) begin
                    exp_conf = 1;
                    if (PRI) exp_r = 1; else exp_s = 1;
                end else begin
                    exp_s = cand[0];
                    exp_r = cand[1];
                end
                m_pend[0] = 0;
                m_pend[1] = 0;
                m_last = m_edge;
            end
        end else begin
            for (int k = 0; k < 2; k++) m_pend[k] = m_pend[k] | ev[k];
        end
        exp_busy = (m_edge - m_last) < LO;
    endtask

    int sc_edge, first_s, first_r, s_cnt, r_cnt, busy_cnt, conf_cnt;

    task automatic begin_scen();
        sc_edge = 0; first_s = -1; first_r = -1;
        s_cnt = 0; r_cnt = 0; busy_cnt = 0; conf_cnt = 0;
    endtask

    task automatic step(input bit rs, input bit si, input bit ci);
        rst = rs;
        bus.set_in = si;
        bus.clr_in = ci;
        @(posedge clk);
        model_step(rs, si, ci);
        #1;
        sc_edge++;
        chk("s", bus.s, exp_s);
        chk("r", bus.r, exp_r);
        chk("busy", bus.busy, exp_busy);
        chk("conflict", bus.conflict, exp_conf);
        chk("s_and_r", bus.s & bus.r, 0);
        if (bus.s) begin s_cnt++; if (first_s < 0) first_s = sc_edge; end
        if (bus.r) begin r_cnt++; if (first_r < 0) first_r = sc_edge; end
        if (bus.busy) busy_cnt++;
        if (bus.conflict) conf_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        int hold_s, hold_r;
        bit vs, vr, rs;
        bus.set_in = 0;
        bus.clr_in = 0;

        // reset with set_in held
        begin_scen();
        step(1, 1, 0);
        step(1, 1, 0);
        chk("rst_quiet", s_cnt + r_cnt + busy_cnt + conf_cnt, 0);
        begin_scen();
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        chk("rst_hold_s_edge", first_s, 5);
        chk("rst_hold_s_cnt", s_cnt, 1);
        chk("rst_hold_busy_cycles", busy_cnt, 2);
        idle(8);

        // glitch rejection
        begin_scen();
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        idle(8);
        chk("glitch_pulses", s_cnt + r_cnt, 0);
        chk("glitch_busy", busy_cnt, 0);

        // collision
        begin_scen();
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        chk("coll_r_edge", first_r, 5);
        chk("coll_conf_cnt", conf_cnt, 1);
        chk("coll_s_cnt", s_cnt, 0);
        idle(8);

        // deferred command
        begin_scen();
        step(0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1);
        chk("defer_s_edge", first_s, 5);
        chk("defer_r_edge", first_r, 8);
        chk("defer_conf_cnt", conf_cnt, 0);
        idle(8);

        // reset mid-lock, inputs stay held and re-qualify together
        begin_scen();
        step(0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        chk("midrst_r_cnt", r_cnt, 0);
        chk("midrst_s_cnt", s_cnt, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1);
        chk("midrst_requal_r_edge", first_r, 11);
        idle(8);

        // long hold
        begin_scen();
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        idle(10);
        chk("long_s_cnt", s_cnt, 1);
        chk("long_r_cnt", r_cnt, 0);

        // randomized segments with occasional reset
        hold_s = 0; hold_r = 0; vs = 0; vr = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_s == 0) begin vs = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 8); end
            if (hold_r == 0) begin vr = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 8); end
            hold_s--;
            hold_r--;
            rs = ($urandom_range(0, 199) == 0);
            step(rs, vs, vr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
